mem_access_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 43 ++++
 rtl/mem_access_ctrl.sv | 145 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side memory access controller:
// default geometry, memory read/write pin encoding and the FSM state
// encoding. The verify states exist only when MEM_CTRL_VERIFY_EN is defined.
package mem_pkg;

    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DEPTH  = 8;

    // Level driven on the memory rw pin.
    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WRITE       = 3'd1,
        ST_RD_ISSUE    = 3'd2,
        ST_RD_CAPTURE  = 3'd3,
        ST_RESP        = 3'd4
`ifdef MEM_CTRL_VERIFY_EN
        ,
        ST_VFY_ISSUE   = 3'd5,
        ST_VFY_CAPTURE = 3'd6
`endif
    } state_t;

    // A verify read fails if the memory did not flag its data as valid
    // or if the byte read back differs from the byte that was stored.
    function automatic logic verify_failed(
        input logic [MEM_DATA_W-1:0] written,
        input logic [MEM_DATA_W-1:0] read_back,
        input logic                  read_ok
    );
        logic fail;
        if (!read_ok) begin
            fail = 1'b1;
        end else begin
            fail = (written != read_back);
        end
        return fail;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store initiator between the CPU
// datapath and the byte memory. Accepts one request in IDLE, sequences the
// memory rw/address/data pins, and returns a one-cycle response.
// Optional build macro: MEM_CTRL_VERIFY_EN adds a read-back after each store
// and flags a mismatch on rsp_err.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     clr,
    // CPU request channel
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic signed [DATA_W-1:0] req_wdata,
    // CPU response channel
    output logic                     rsp_valid,
    output logic signed [DATA_W-1:0] rsp_rdata,
    output logic                     rsp_err,
    // Memory pins
    output logic                     mem_clr,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_address,
    output logic signed [DATA_W-1:0] mem_data_in,
    input  logic signed [DATA_W-1:0] mem_data_out,
    input  logic                     mem_out_valid
);

    // One extra bit so DEPTH itself is representable in the range compare.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t                     state_r;
    logic                       rsp_valid_r;
    logic                       rsp_err_r;
    logic signed [DATA_W-1:0]   rsp_rdata_r;
    logic                       mem_rw_r;
    logic [ADDR_W-1:0]          mem_address_r;
    logic signed [DATA_W-1:0]   mem_data_in_r;
    logic                       addr_ok_s;

    // Address range check on the incoming request.
    always_comb begin
        addr_ok_s = 1'b0;
        if ({1'b0, req_addr} < DEPTH_LIM) begin
            addr_ok_s = 1'b1;
        end else begin
            addr_ok_s = 1'b0;
        end
    end

    // Controller FSM with registered response and memory-pin outputs.
    // mem_address and mem_data_in double as the captured request fields;
    // they only change when an in-range request is accepted.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r       <= ST_IDLE;
            rsp_valid_r   <= 1'b0;
            rsp_err_r     <= 1'b0;
            rsp_rdata_r   <= '0;
            mem_rw_r      <= MEM_RD;
            mem_address_r <= '0;
            mem_data_in_r <= '0;
        end else begin
            rsp_valid_r <= 1'b0;
            mem_rw_r    <= MEM_RD;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (!addr_ok_s) begin
                            state_r     <= ST_RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                        end else if (req_we) begin
                            state_r       <= ST_WRITE;
                            mem_rw_r      <= MEM_WR;
                            mem_address_r <= req_addr;
                            mem_data_in_r <= req_wdata;
                        end else begin
                            state_r       <= ST_RD_ISSUE;
                            mem_address_r <= req_addr;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
`ifdef MEM_CTRL_VERIFY_EN
                    state_r <= ST_VFY_ISSUE;
`else
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b0;
`endif
                end
                ST_RD_ISSUE: begin
                    // Memory registers the addressed byte at this closing edge.
                    state_r <= ST_RD_CAPTURE;
                end
                ST_RD_CAPTURE: begin
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    if (mem_out_valid) begin
                        rsp_rdata_r <= mem_data_out;
                        rsp_err_r   <= 1'b0;
                    end else begin
                        rsp_err_r   <= 1'b1;
                    end
                end
`ifdef MEM_CTRL_VERIFY_EN
                ST_VFY_ISSUE: begin
                    state_r <= ST_VFY_CAPTURE;
                end
                ST_VFY_CAPTURE: begin
                    // Read-back is compared only; rsp_rdata keeps the last load.
                    state_r     <= ST_RESP;
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= verify_failed(mem_data_in_r, mem_data_out,
                                                 mem_out_valid);
                end
`endif
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_r == ST_IDLE);
    assign rsp_valid   = rsp_valid_r;
    assign rsp_err     = rsp_err_r;
    assign rsp_rdata   = rsp_rdata_r;
    assign mem_clr     = clr;
    assign mem_rw      = mem_rw_r;
    assign mem_address = mem_address_r;
    assign mem_data_in = mem_data_in_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Contains a behavioural byte
// memory (registered read, clear, rw pin) and a reference model built from
// an array of expected memory contents plus per-request expected latencies.
module tb_mem_access_ctrl;

`ifdef MEM_CTRL_VERIFY_EN
    localparam bit VFY_ON  = 1'b1;
    localparam int STORE_K = 4;
`else
    localparam bit VFY_ON  = 1'b0;
    localparam int STORE_K = 2;
`endif
    localparam int LOAD_K = 3;
    localparam int ERR_K  = 1;

    logic              clk = 1'b0;
    logic              clr = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [3:0]        req_addr = 4'd0;
    logic signed [7:0] req_wdata = 8'sd0;
    logic              rsp_valid;
    logic signed [7:0] rsp_rdata;
    logic              rsp_err;
    logic              mem_clr;
    logic              mem_rw;
    logic [3:0]        mem_address;
    logic signed [7:0] mem_data_in;
    logic signed [7:0] mem_data_out;
    logic              mem_out_valid;

    int total = 0;
    int bad   = 0;

    // Memory environment
    logic signed [7:0] mem [0:15];
    logic signed [7:0] mem_dout;
    bit                corrupt = 1'b0;
    bit                prefill = 1'b0;

    // Reference model state
    logic signed [7:0] ref_mem [0:7];
    logic signed [7:0] ref_rdata;

    mem_access_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_clr      (mem_clr),
        .mem_rw       (mem_rw),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_out_valid(mem_out_valid)
    );

    always #5 clk = ~clk;

    // Byte memory: synchronous clear, write on rw=1, registered read on rw=0.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'sd0;
            mem_dout <= 8'sd0;
        end else if (prefill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i + 17);
        end else if (mem_rw) begin
            mem[mem_address] <= mem_data_in;
        end else begin
            mem_dout <= mem[mem_address];
        end
    end

    assign mem_data_out  = corrupt ? ~mem_dout : mem_dout;
    assign mem_out_valid = ~mem_rw;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One request from presentation to response, checked against the model.
    task automatic run_req(input string name, input logic we,
                           input logic [3:0] addr, input logic signed [7:0] wd);
        int   wait_n, k, rw_n, exp_k, exp_rw;
        logic exp_err;
        bit   got;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL %s accept: req_ready=%0b required 1", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (addr >= 4'd8) begin
            exp_k = ERR_K; exp_err = 1'b1; exp_rw = 0;
        end else if (we) begin
            exp_k = STORE_K; exp_err = VFY_ON ? corrupt : 1'b0; exp_rw = 1;
            ref_mem[addr[2:0]] = wd;
        end else begin
            exp_k = LOAD_K; exp_err = 1'b0; exp_rw = 0;
            ref_rdata = ref_mem[addr[2:0]];
        end
        k = 1; rw_n = 0; got = 1'b0;
        while (!got && k <= 10) begin
            if (mem_rw) rw_n++;
            if (rsp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        total++;
        if (!got || k != exp_k) begin
            bad++;
            $display("FAIL %s latency: got=%0d required=%0d", name, got ? k : -1, exp_k);
        end
        total++;
        if (rsp_err !== exp_err) begin
            bad++;
            $display("FAIL %s rsp_err: got=%0b required=%0b", name, rsp_err, exp_err);
        end
        total++;
        if (rsp_rdata !== ref_rdata) begin
            bad++;
            $display("FAIL %s rsp_rdata: got=%0d required=%0d", name, rsp_rdata, ref_rdata);
        end
        @(negedge clk);
        if (mem_rw) rw_n++;
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s pulse: rsp_valid=%0b required 0", name, rsp_valid);
        end
        total++;
        if (rw_n != exp_rw) begin
            bad++;
            $display("FAIL %s mem_rw cycles: got=%0d required=%0d", name, rw_n, exp_rw);
        end
    endtask

    task automatic test_reset();
        bit mem_zero;
        @(negedge clk);
        prefill = 1'b1;
        @(negedge clk);
        prefill = 1'b0;
        clr = 1'b1;
        #1;
        total++;
        if (mem_clr !== 1'b1) begin
            bad++;
            $display("FAIL reset mem_clr: got=%0b required 1", mem_clr);
        end
        repeat (2) @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'sd0;
        ref_rdata = 8'sd0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_rw !== 1'b0) begin
            bad++;
            $display("FAIL reset ctl: ready=%0b valid=%0b err=%0b rw=%0b required 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, mem_rw);
        end
        total++;
        if (rsp_rdata !== 8'sd0 || mem_address !== 4'd0 || mem_data_in !== 8'sd0) begin
            bad++;
            $display("FAIL reset data: rdata=%0d addr=%0d din=%0d required 0 0 0",
                     rsp_rdata, mem_address, mem_data_in);
        end
        mem_zero = 1'b1;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'sd0) mem_zero = 1'b0;
        total++;
        if (!mem_zero) begin
            bad++;
            $display("FAIL reset memory: contents not cleared, mem[0]=%0d required 0", mem[0]);
        end
    endtask

    task automatic test_store_load();
        run_req("store_5a", 1'b1, 4'd3, 8'sh5A);
        run_req("load_5a", 1'b0, 4'd3, 8'sd0);
        total++;
        if (rsp_rdata !== 8'sh5A) begin
            bad++;
            $display("FAIL load_5a value: got=%0h required=5a", rsp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, n;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = -8'sd8;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        t0 = cyc;
        @(negedge clk);
        req_we = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        t1 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        ref_mem[7] = -8'sd8;
        ref_rdata  = -8'sd8;
        total++;
        if (t1 - t0 != STORE_K + 1) begin
            bad++;
            $display("FAIL b2b accept gap: got=%0d required=%0d", t1 - t0, STORE_K + 1);
        end
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        total++;
        if (!rsp_valid || n != LOAD_K - 1 || rsp_err !== 1'b0 || rsp_rdata !== -8'sd8) begin
            bad++;
            $display("FAIL b2b load: valid=%0b delay=%0d err=%0b rdata=%0d required 1 %0d 0 -8",
                     rsp_valid, n, rsp_err, rsp_rdata, LOAD_K - 1);
        end
    endtask

    task automatic test_out_of_range();
        run_req("load_oor9", 1'b0, 4'd9, 8'sd0);
        run_req("store_oor15", 1'b1, 4'd15, 8'sh33);
    endtask

    task automatic test_clr_mid();
        int n, seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'sd0;
        ref_rdata = 8'sd0;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_mid ready: got=%0b required 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL clr_mid rsp_valid: pulses=%0d required 0", seen);
        end
        total++;
        if (rsp_rdata !== ref_rdata || mem[3] !== 8'sd0) begin
            bad++;
            $display("FAIL clr_mid state: rdata=%0d mem3=%0d required 0 0", rsp_rdata, mem[3]);
        end
    endtask

`ifdef MEM_CTRL_VERIFY_EN
    task automatic test_verify();
        corrupt = 1'b1;
        run_req("verify_bad", 1'b1, 4'd1, 8'sh11);
        corrupt = 1'b0;
        run_req("verify_good", 1'b1, 4'd1, 8'sh11);
    endtask
`endif

    task automatic test_random();
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;
        for (int t = 0; t < 40; t++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 4'($urandom_range(0, 11));
            wd   = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_req($sformatf("rand%0d", t), we, addr, wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_out_of_range();
        test_clr_mid();
`ifdef MEM_CTRL_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
